fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if_id_reg.sv | 62 ++++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared RISC-V fetch definitions: the NOP encoding, the fetch FSM states and
// the helper that word-aligns redirect targets.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats stall, and stall beats load.
// Any cycle that is neither stalled nor loading inserts a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush || (!stall && !load)) begin
      instr_d    = NOP_INSTR;
      pc_d       = 32'd0;
      pc_plus4_d = 32'd0;
      valid_d    = 1'b0;
    end else if (!stall) begin
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PCF register, the single-outstanding request FSM and
// the IF/ID register. Redirects and flushes retire stale responses safely.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReqValid,
  input  logic        IMemReqReady,
  output logic [31:0] IMemAddr,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRspData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        InstrValidD,
  output logic [1:0]  dbg_state
);

  // Request handshake: a request transfers in the cycle where IMemReqValid and
  // IMemReqReady are both 1; once raised in REQ, valid and address stay put
  // until that transfer, except that a redirect may replace the address.
  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  hold_q, hold_d;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         load;
  logic [31:0]  load_instr;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;

  assign pc_plus4 = pcf_q + 32'd4;
  assign target   = align_word(PCTargetE);

  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    hold_d     = hold_q;
    req_valid  = 1'b0;
    req_addr   = pcf_q;
    load       = 1'b0;
    load_instr = IMemRspData;
    case (state_q)
      ST_REQ: begin
        req_valid = 1'b1;
        if (PCSrcE) begin
          pcf_d = target;
          if (IMemReqReady) state_d = ST_DROP;
        end else if (IMemReqReady) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!IMemRspValid) begin
          if (PCSrcE) begin
            pcf_d   = target;
            state_d = ST_DROP;
          end
        end else if (PCSrcE || FlushD) begin
          pcf_d   = PCSrcE ? target : pc_plus4;
          state_d = ST_REQ;
        end else if (StallD) begin
          hold_d  = IMemRspData;
          state_d = ST_HOLD;
        end else begin
          // Deliver and issue the next sequential fetch in the same cycle.
          load      = 1'b1;
          pcf_d     = pc_plus4;
          req_valid = 1'b1;
          req_addr  = pc_plus4;
          state_d   = IMemReqReady ? ST_WAIT : ST_REQ;
        end
      end
      ST_DROP: begin
        if (PCSrcE) pcf_d = target;
        if (IMemRspValid) state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (PCSrcE || FlushD) begin
          pcf_d   = PCSrcE ? target : pc_plus4;
          state_d = ST_REQ;
        end else if (!StallD) begin
          load       = 1'b1;
          load_instr = hold_q;
          pcf_d      = pc_plus4;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
      pcf_q   <= RESET_PC;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      hold_q  <= hold_d;
    end
  end

  assign IMemReqValid = req_valid && !reset;
  assign IMemAddr     = req_addr;
  assign dbg_state    = state_q;

  if_id_reg u_if_id (
    .clk         (clk),
    .reset       (reset),
    .flush       (FlushD),
    .stall       (StallD),
    .load        (load),
    .instr_in    (load_instr),
    .pc_in       (pcf_q),
    .pc_plus4_in (pc_plus4),
    .instr_o     (InstrD),
    .pc_o        (PCD),
    .pc_plus4_o  (PCPlus4D),
    .valid_o     (InstrValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: 1-deep memory responder, transaction-level fetch model
// checked every cycle, and hand-computed checkpoints for the directed scenarios.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, StallD, FlushD, PCSrcE, IMemReqReady, IMemRspValid;
  logic [31:0] PCTargetE, IMemRspData;
  logic        IMemReqValid, InstrValidD;
  logic [31:0] IMemAddr, InstrD, PCD, PCPlus4D;
  logic [1:0]  dbg_state;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .IMemReqValid(IMemReqValid), .IMemReqReady(IMemReqReady), .IMemAddr(IMemAddr),
    .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrValidD(InstrValidD),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // memory responder state
  logic        mem_pending;
  logic [31:0] mem_addr;

  // fetch model: next wanted address, outstanding request, held response
  logic [31:0] m_pc;
  logic        m_out, m_doomed, m_held, m_init, m_fresh;
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bubble_model();
    e_instr = NOP_INSTR; e_pc = 32'd0; e_pc4 = 32'd0; e_v = 1'b0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance model.
  task automatic cyc(input logic rst, input logic stall, input logic flush,
                     input logic pcsrc, input logic [31:0] tgt,
                     input logic rdy, input logic rsp_en);
    logic        rsp, exp_rv, dlv;
    logic [31:0] exp_ra, t, d_pc, got;
    @(negedge clk);
    reset = rst; StallD = stall; FlushD = flush; PCSrcE = pcsrc;
    PCTargetE = tgt; IMemReqReady = rdy;
    rsp = mem_pending && rsp_en;
    IMemRspValid = rsp;
    IMemRspData  = rsp ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = 1'b0;
    exp_ra = m_pc;
    if (!rst && !m_held) begin
      if (!m_out) exp_rv = 1'b1;
      else if (!m_doomed && rsp && !pcsrc && !flush && !stall) begin
        exp_rv = 1'b1;
        exp_ra = m_pc + 32'd4;
      end
    end
    check("req_valid", {31'd0, IMemReqValid}, {31'd0, exp_rv});
    if (exp_rv) check("req_addr", IMemAddr, exp_ra);
    if (m_init) begin
      check("instr_d", InstrD, e_instr);
      check("pc_d", PCD, e_pc);
      check("pc_plus4_d", PCPlus4D, e_pc4);
      check("valid_d", {31'd0, InstrValidD}, {31'd0, e_v});
    end
    if (m_fresh) begin
      if (exp_q.size() == 0) check("stream_empty", 32'd1, 32'd0);
      else begin
        got = exp_q.pop_front();
        check("stream", InstrD, got);
      end
    end
    // memory responder
    if (rst) mem_pending = 1'b0;
    else begin
      if (rsp) mem_pending = 1'b0;
      if (IMemReqValid && rdy) begin
        mem_pending = 1'b1;
        mem_addr    = IMemAddr;
      end
    end
    // model advance
    t = tgt & 32'hFFFF_FFFC;
    dlv = 1'b0;
    d_pc = m_pc;
    if (rst) begin
      m_pc = RESET_PC; m_out = 1'b0; m_doomed = 1'b0; m_held = 1'b0;
      m_init = 1'b1; m_fresh = 1'b0;
      bubble_model();
    end else begin
      if (m_held) begin
        if (pcsrc) begin m_pc = t; m_held = 1'b0; end
        else if (flush) begin m_pc = m_pc + 32'd4; m_held = 1'b0; end
        else if (!stall) begin dlv = 1'b1; d_pc = m_pc; m_pc = m_pc + 32'd4; m_held = 1'b0; end
      end else if (m_out && m_doomed) begin
        if (pcsrc) m_pc = t;
        if (rsp) begin m_out = 1'b0; m_doomed = 1'b0; end
      end else if (m_out) begin
        if (rsp) begin
          m_out = 1'b0;
          if (pcsrc) m_pc = t;
          else if (flush) m_pc = m_pc + 32'd4;
          else if (stall) m_held = 1'b1;
          else begin
            dlv = 1'b1; d_pc = m_pc; m_pc = m_pc + 32'd4;
            if (rdy) m_out = 1'b1;
          end
        end else if (pcsrc) begin
          m_pc = t; m_doomed = 1'b1;
        end
      end else begin
        if (rdy) begin m_out = 1'b1; m_doomed = pcsrc; end
        if (pcsrc) m_pc = t;
      end
      m_fresh = 1'b0;
      if (flush) bubble_model();
      else if (stall) begin end
      else if (dlv) begin
        e_instr = mem_word(d_pc); e_pc = d_pc; e_pc4 = d_pc + 32'd4; e_v = 1'b1;
        m_fresh = 1'b1;
        exp_q.push_back(mem_word(d_pc));
      end else bubble_model();
    end
  endtask

  task automatic run(input logic stall, input logic flush, input logic pcsrc,
                     input logic [31:0] tgt, input logic rdy, input logic rsp_en);
    cyc(1'b0, stall, flush, pcsrc, tgt, rdy, rsp_en);
  endtask

  initial begin
    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    IMemReqReady = 1'b0; IMemRspValid = 1'b0; IMemRspData = 32'd0;
    mem_pending = 1'b0; mem_addr = 32'd0;
    m_pc = RESET_PC; m_out = 1'b0; m_doomed = 1'b0; m_held = 1'b0;
    m_init = 1'b0; m_fresh = 1'b0;
    bubble_model();

    cyc(1'b1, 0, 0, 0, 32'd0, 1, 1);
    check("rst_req_valid", {31'd0, IMemReqValid}, 32'd0);
    cyc(1'b1, 0, 0, 0, 32'd0, 1, 1);

    // straight-line fetch
    run(0, 0, 0, 32'd0, 1, 1);
    check("c0_addr", IMemAddr, 32'h0);
    check("c0_valid", {31'd0, IMemReqValid}, 32'd1);
    check("c0_instr_nop", InstrD, 32'h0000_0013);
    check("c0_pcd", PCD, 32'h0);
    check("c0_vld", {31'd0, InstrValidD}, 32'd0);
    run(0, 0, 0, 32'd0, 1, 1);
    check("c1_addr", IMemAddr, 32'h4);
    run(0, 0, 0, 32'd0, 1, 1);
    check("c2_instr", InstrD, 32'hC0DE_0003);
    check("c2_pc4", PCPlus4D, 32'h4);
    check("c2_vld", {31'd0, InstrValidD}, 32'd1);
    check("c2_addr", IMemAddr, 32'h8);

    // stall while the 0x8 response arrives
    run(1, 0, 0, 32'd0, 1, 1);
    check("st0_noreq", {31'd0, IMemReqValid}, 32'd0);
    check("st0_instr", InstrD, 32'hC0DE_0007);
    run(1, 0, 0, 32'd0, 1, 1);
    check("st1_state_hold", {30'd0, dbg_state}, 32'd3);
    check("st1_instr", InstrD, 32'hC0DE_0007);
    run(1, 0, 0, 32'd0, 1, 1);
    check("st2_noreq", {31'd0, IMemReqValid}, 32'd0);
    run(0, 0, 0, 32'd0, 1, 1);
    run(0, 0, 0, 32'd0, 1, 1);
    check("rel_instr", InstrD, 32'hC0DE_000B);
    check("rel_pcd", PCD, 32'h8);
    check("rel_addr", IMemAddr, 32'hC);

    // redirect while waiting on 0x10
    run(0, 0, 0, 32'd0, 1, 1);
    run(0, 0, 1, 32'h100, 1, 0);
    check("rd_noreq", {31'd0, IMemReqValid}, 32'd0);
    run(0, 0, 0, 32'd0, 1, 1);
    check("rd_state_drop", {30'd0, dbg_state}, 32'd2);
    check("rd_drop_noreq", {31'd0, IMemReqValid}, 32'd0);
    run(0, 0, 0, 32'd0, 1, 1);
    check("rd_addr", IMemAddr, 32'h100);
    check("rd_no_stale", {31'd0, InstrValidD && (PCD == 32'h10)}, 32'd0);
    run(0, 0, 0, 32'd0, 1, 1);
    check("rd_addr2", IMemAddr, 32'h104);
    check("rd_no_stale2", {31'd0, InstrValidD && (PCD == 32'h10)}, 32'd0);

    // memory not ready
    run(0, 0, 0, 32'd0, 0, 1);
    check("nr_instr", InstrD, 32'hC0DE_0103);
    check("nr_pcd", PCD, 32'h100);
    for (int i = 0; i < 5; i++) begin
      run(0, 0, 0, 32'd0, 0, 1);
      check("nr_valid", {31'd0, IMemReqValid}, 32'd1);
      check("nr_addr", IMemAddr, 32'h108);
      if (i > 0) begin
        check("nr_nop", InstrD, 32'h0000_0013);
        check("nr_vld", {31'd0, InstrValidD}, 32'd0);
      end
    end
    run(0, 0, 0, 32'd0, 1, 1);
    run(0, 0, 0, 32'd0, 1, 1);

    // flush and stall together
    run(1, 1, 0, 32'd0, 1, 1);
    check("fs_pre_instr", InstrD, 32'hC0DE_010B);
    run(0, 0, 1, 32'hFFFF_FFFE, 1, 1);
    check("fs_nop", InstrD, 32'h0000_0013);
    check("fs_pcd", PCD, 32'h0);
    check("fs_pc4", PCPlus4D, 32'h0);
    check("fs_vld", {31'd0, InstrValidD}, 32'd0);
    check("fs_addr", IMemAddr, 32'h110);

    // wrap at the top of the address space
    run(0, 0, 0, 32'd0, 1, 1);
    run(0, 0, 0, 32'd0, 1, 1);
    check("wr_addr", IMemAddr, 32'hFFFF_FFFC);
    run(0, 0, 0, 32'd0, 1, 1);
    check("wr_next_addr", IMemAddr, 32'h0);
    run(0, 0, 0, 32'd0, 1, 1);
    check("wr_instr", InstrD, 32'h3F21_FFFF);
    check("wr_pcd", PCD, 32'hFFFF_FFFC);
    check("wr_pc4", PCPlus4D, 32'h0);

    // mixed traffic
    for (int i = 0; i < 80; i++) begin
      run(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0), $urandom(),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    // reset in the middle of traffic
    cyc(1'b1, 0, 0, 0, 32'd0, 1, 1);
    run(0, 0, 0, 32'd0, 1, 1);
    check("rr_addr", IMemAddr, 32'h0);
    check("rr_vld", {31'd0, InstrValidD}, 32'd0);
    for (int i = 0; i < 4; i++) run(0, 0, 0, 32'd0, 1, 1);
    for (int i = 0; i < 3; i++) run(0, 0, 0, 32'd0, 0, 1);
    check("stream_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
